// File: rtl/ifetch_hs32.sv
// Instruction fetch stage: owns the PC, fetches over a req/gnt/rvalid port and hands one
// instruction at a time to decode. Optional ALIGN_CHK_EN traps misaligned next-PC targets.
module ifetch_hs32 #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        Branch,
    input  logic        nBranch,
    input  logic        Jmp,
    input  logic        Jal,
    input  logic        Jr,
    input  logic        Zero,
    input  logic [31:0] Addr_result,
    input  logic [31:0] Read_data_1,
    input  logic        hold,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] Instruction,
    output logic [31:0] opcplus4,
    output logic        inst_valid,
    output logic        fetch_err
);

    typedef enum logic [1:0] {StRst, StFetch, StWait, StExec} state_e;

    state_e      state_q;
    logic [31:0] pc_q;
    logic [31:0] instr_q;
    logic        req_q;
    logic        valid_q;
    logic        err_q;

    logic [31:0] target;
    logic [31:0] next_pc;
    logic        misaligned;

    assign opcplus4    = pc_q + 32'd4;
    assign imem_addr   = pc_q;
    assign imem_req    = req_q;
    assign Instruction = instr_q;
    assign inst_valid  = valid_q;
    assign fetch_err   = err_q;

    always_comb begin
        target = opcplus4;
        if (Jr) begin
            target = Read_data_1;
        end else if (Jmp | Jal) begin
            target = {opcplus4[31:28], instr_q[25:0], 2'b00};
        end else if ((Branch & Zero) | (nBranch & ~Zero)) begin
            target = Addr_result;
        end
    end

`ifdef ALIGN_CHK_EN
    assign misaligned = |target[1:0];
    assign next_pc    = target;
`else
    assign misaligned = 1'b0;
    assign next_pc    = target & ~32'd3;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StRst;
            pc_q    <= RESET_PC;
            instr_q <= 32'd0;
            req_q   <= 1'b0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            unique case (state_q)
                StRst: begin
                    state_q <= StFetch;
                    req_q   <= 1'b1;
                end
                StFetch: begin
                    if (imem_gnt) begin
                        req_q <= 1'b0;
                        if (imem_rvalid) begin
                            instr_q <= imem_rdata;
                            valid_q <= 1'b1;
                            state_q <= StExec;
                        end else begin
                            state_q <= StWait;
                        end
                    end
                end
                StWait: begin
                    if (imem_rvalid) begin
                        instr_q <= imem_rdata;
                        valid_q <= 1'b1;
                        state_q <= StExec;
                    end
                end
                StExec: begin
                    // A trapped misaligned target parks here until reset.
                    if (!err_q && !hold) begin
                        if (misaligned) begin
                            err_q   <= 1'b1;
                            valid_q <= 1'b0;
                        end else begin
                            pc_q    <= next_pc;
                            valid_q <= 1'b0;
                            req_q   <= 1'b1;
                            state_q <= StFetch;
                        end
                    end
                end
                default: state_q <= StRst;
            endcase
        end
    end

endmodule
